fe_req_arbiter: RTL and testbench

//  Round-robin scheduler for front-end data requests (ptr, ptp, dis340, ...) toward the HPS.

---
 rtl/fe_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_fe_req_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fe_req_arbiter.sv
// fe_req_arbiter: round-robin scheduler for front-end data requests toward the HPS.
// Grants one requesting device at a time, raises irq while the grant is outstanding and
// holds it until the HPS writes the ACK register over the Avalon-MM slave.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   req          level requests from device front-ends [NREQ-1:0]
//   irq          high while a grant is outstanding
//   s_address    Avalon word address (0 STATUS, 1 PENDING, 2 ACK, 3 MASK)
//   s_read       Avalon read strobe
//   s_write      Avalon write strobe
//   s_writedata  Avalon write data
//   s_readdata   Avalon read data, read latency 1, no waitrequest
//
// Optional feature: define FE_ARB_TIMEOUT_EN to release a grant automatically after
// TIMEOUT cycles without ACK and report it in STATUS[30].
module fe_req_arbiter #(
   parameter int unsigned NREQ    = 3,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   output logic            irq,
   input  logic [1:0]      s_address,
   input  logic            s_read,
   input  logic            s_write,
   input  logic [31:0]     s_writedata,
   output logic [31:0]     s_readdata
);

   if (NREQ < 1 || NREQ > 32 || TIMEOUT < 1) begin : g_bad_param
      $error("fe_req_arbiter: NREQ must be 1..32 and TIMEOUT at least 1");
   end

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e          state_q, state_d;
   logic [4:0]      gnt_id_q, last_q, winner;
   logic [NREQ-1:0] mask_q, req_m;
   logic            any_req, ack, tmo_hit, tmo_flag_q, req_live, found;
   logic [31:0]     status;
   logic            unused_wdata;

   assign req_m        = req & mask_q;
   assign any_req      = |req_m;
   assign ack          = s_write && (s_address == 2'd2) && (state_q == StGrant);
   // Only the low NREQ bits of the write data are ever stored.
   assign unused_wdata = ^s_writedata;

   // Winner: first set bit above last, else wrap to the lowest set bit (which may be last).
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && req_m[j] && (5'(j) > last_q)) begin
            winner = 5'(j);
            found  = 1'b1;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!found && req_m[j]) begin
            winner = 5'(j);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      req_live = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (5'(j) == gnt_id_q) req_live = req[j];
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any_req) state_d = StGrant;
         StGrant: if (ack || tmo_hit) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      irq = (state_q == StGrant);
   end

   // Grant bookkeeping; gnt_id and last are frozen for the whole GRANT period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_id_q <= '0;
         last_q   <= 5'(NREQ - 1);
      end else if (state_q == StIdle && any_req) begin
         gnt_id_q <= winner;
         last_q   <= winner;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 mask_q <= '1;
      else if (s_write && (s_address == 2'd3))   mask_q <= s_writedata[NREQ-1:0];
   end

`ifdef FE_ARB_TIMEOUT_EN
   logic [31:0] tmo_cnt_q;

   assign tmo_hit = (state_q == StGrant) && !ack && (tmo_cnt_q == TIMEOUT - 1);

   // Counter idles at zero so it starts from zero on every GRANT entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q  <= '0;
         tmo_flag_q <= 1'b0;
      end else begin
         tmo_cnt_q <= (state_q == StGrant) ? tmo_cnt_q + 32'd1 : 32'd0;
         // A timeout in the same cycle as a clearing STATUS read keeps the flag set.
         if (tmo_hit)                              tmo_flag_q <= 1'b1;
         else if (s_read && (s_address == 2'd0))   tmo_flag_q <= 1'b0;
      end
   end
`else
   assign tmo_hit    = 1'b0;
   assign tmo_flag_q = 1'b0;
`endif

   assign status = {(state_q == StGrant), tmo_flag_q, req_live, 24'd0, gnt_id_q};

   // Registered read path samples pre-write register values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_readdata <= '0;
      end else if (s_read) begin
         unique case (s_address)
            2'd0:    s_readdata <= status;
            2'd1:    s_readdata <= 32'(req_m);
            2'd2:    s_readdata <= '0;
            default: s_readdata <= 32'(mask_q);
         endcase
      end
   end

endmodule

// File: tb/tb_fe_req_arbiter.sv
module tb_fe_req_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  req = 3'b000;
   logic        irq;
   logic [1:0]  s_address = 2'd0;
   logic        s_read = 1'b0;
   logic        s_write = 1'b0;
   logic [31:0] s_writedata = 32'd0;
   logic [31:0] s_readdata;

   int total = 0;
   int bad = 0;
   logic [31:0] rdata;

   fe_req_arbiter #(.NREQ(3), .TIMEOUT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .irq         (irq),
      .s_address   (s_address),
      .s_read      (s_read),
      .s_write     (s_write),
      .s_writedata (s_writedata),
      .s_readdata  (s_readdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] addr, output logic [31:0] data);
      s_address = addr;
      s_read    = 1'b1;
      tick();
      s_read = 1'b0;
      data   = s_readdata;
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      s_address   = addr;
      s_writedata = data;
      s_write     = 1'b1;
      tick();
      s_write = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   initial begin
      // 1: reset state
      tick();
      do_reset();
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", s_readdata, 32'd0);
      rd(2'd0, rdata); check("rst_status", rdata, 32'h0000_0000);
      rd(2'd3, rdata); check("rst_mask", rdata, 32'h0000_0007);
      check("idle_irq", 32'(irq), 32'd0);

      // 2: single request, ACK, regrant after one-cycle gap
      req = 3'b001;
      tick();
      check("t2_irq_on", 32'(irq), 32'd1);
      rd(2'd0, rdata); check("t2_status", rdata, 32'hA000_0000);
      wr(2'd2, 32'd1);
      check("t2_irq_gap", 32'(irq), 32'd0);
      tick();
      check("t2_irq_again", 32'(irq), 32'd1);
      rd(2'd0, rdata); check("t2_status2", rdata, 32'hA000_0000);
      req = 3'b000;
      wr(2'd2, 32'd0);
      tick();
      check("t2_idle", 32'(irq), 32'd0);
      wr(2'd2, 32'd0);   // ACK in IDLE is ignored
      check("t2_ack_idle", 32'(irq), 32'd0);

      // 3: round robin 0,1,2,0,1 with one-cycle irq gaps
      do_reset();
      req = 3'b111;
      tick();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t3_irq_%0d", k), 32'(irq), 32'd1);
         rd(2'd0, rdata);
         check($sformatf("t3_gnt_%0d", k), rdata, 32'hA000_0000 | 32'(k % 3));
         wr(2'd2, 32'd0);
         check($sformatf("t3_gap_%0d", k), 32'(irq), 32'd0);
         tick();
      end

      // 4: grant held through req drop and mask change
      do_reset();
      req = 3'b010;
      tick();
      rd(2'd0, rdata); check("t4_gnt1", rdata, 32'hA000_0001);
      req = 3'b100;
      wr(2'd3, 32'h5);
      rd(2'd0, rdata); check("t4_held", rdata, 32'h8000_0001);
      check("t4_irq", 32'(irq), 32'd1);
      rd(2'd3, rdata); check("t4_mask", rdata, 32'h0000_0005);
      rd(2'd1, rdata); check("t4_pend_a", rdata, 32'h0000_0004);
      req = 3'b111;
      rd(2'd1, rdata); check("t4_pend_b", rdata, 32'h0000_0005);
      rd(2'd2, rdata); check("t4_ack_rd", rdata, 32'h0000_0000);
      wr(2'd2, 32'd0);
      check("t4_gap", 32'(irq), 32'd0);
      tick();
      rd(2'd0, rdata); check("t4_next", rdata, 32'hA000_0002);

      // 5: asynchronous reset mid-GRANT
      reset = 1'b1;
      #1;
      check("t5_irq_async", 32'(irq), 32'd0);
      check("t5_rdata_async", s_readdata, 32'd0);
      #2;
      reset = 1'b0;
      req = 3'b100;
      tick();
      rd(2'd0, rdata); check("t5_gnt2", rdata, 32'hA000_0002);
      rd(2'd3, rdata); check("t5_mask", rdata, 32'h0000_0007);

      // Simultaneous read and write of MASK returns the old value; upper bits are dropped
      s_address = 2'd3; s_writedata = 32'h0000_0001; s_read = 1'b1; s_write = 1'b1;
      tick();
      s_read = 1'b0; s_write = 1'b0;
      check("rw_old", s_readdata, 32'h0000_0007);
      rd(2'd3, rdata); check("rw_new", rdata, 32'h0000_0001);
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd3, rdata); check("mask_wide", rdata, 32'h0000_0007);

`ifdef FE_ARB_TIMEOUT_EN
      // 6: timeout after 8 GRANT cycles, flag cleared by STATUS read
      do_reset();
      req = 3'b011;
      tick();
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t6_hold_%0d", i), 32'(irq), 32'd1);
         tick();
      end
      check("t6_irq_off", 32'(irq), 32'd0);
      rd(2'd0, rdata); check("t6_tmo_flag", rdata, 32'h6000_0000);
      rd(2'd0, rdata); check("t6_next", rdata, 32'hA000_0001);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
